// File: rtl/pipe_adder_pkg.sv
// Shared constants and per-stage payload layout for the pipelined adder.
// Default geometry is a 16-bit adder split into four carry slices.
package pipe_adder_pkg;

  localparam int PA_WIDTH  = 16;
  localparam int PA_STAGES = 4;

  // Control fields carried by every pipeline stage.
  // cy is the carry leaving the slice this stage completed (carry-in for the
  // next slice); at the entry it is the carry into slice 0.
  typedef struct packed {
    logic vld;
    logic cy;
    logic sub;
    logic ov;
  } stage_ctl_t;

  // Full stage payload at the default width: control, skewed operands and the
  // partial sum built up one slice per stage.
  typedef struct packed {
    stage_ctl_t          ctl;
    logic [PA_WIDTH-1:0] a;
    logic [PA_WIDTH-1:0] b;
    logic [PA_WIDTH-1:0] s;
  } stage_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple slice: sum, carry out and carry into the MSB.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage decides when to capture.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s    = full[W-1:0];
  assign cout = full[W];
  // The MSB sum bit is a^b^carry_in, so the carry into it falls out directly;
  // this also holds for a 1-bit slice.
  assign cmsb = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder, carry chain cut into STAGES slices (optional subtract: PIPE_ADDER_SUB_EN).
// Latency: STAGES cycles from input handshake to out_valid, one result per cycle.
// Backpressure: valid/ready per stage, bubbles collapse; in_ready = stage 0 empty or advancing.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = PA_WIDTH,
  parameter int STAGES = PA_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  if (WIDTH < 4 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be >= 4 and a multiple of STAGES (>= 1)");
  end

  // Same layout as the package stage_t, rebuilt at this instance's WIDTH.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } slot_t;

  slot_t             st_q  [STAGES];
  slot_t             nxt   [STAGES];
  slot_t             entry;
  logic [STAGES-1:0] rdy;
  logic              sub_i;

`ifdef PIPE_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  // Entry payload; subtract forces carry-in to 1 and rides along as ctl.sub.
  always_comb begin
    entry         = '0;
    entry.ctl.vld = in_valid;
    entry.ctl.sub = sub_i;
    entry.ctl.cy  = sub_i ? 1'b1 : cin;
    entry.a       = a;
    entry.b       = b;
  end

  // Ready ripples back from the output: a stage can load if empty or draining.
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = !st_q[STAGES-1].ctl.vld || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      rdy[k] = !st_q[k].ctl.vld || rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    slot_t          in_s;
    slot_t          nx;
    logic [SW-1:0]  sl_b;
    logic [SW-1:0]  sl_s;
    logic           sl_c;
    logic           sl_m;

    if (k == 0) begin : g_first
      assign in_s = entry;
    end else begin : g_next
      assign in_s = st_q[k-1];
    end

    // Subtract inverts B slice-by-slice using the sub bit travelling with it.
    assign sl_b = in_s.b[k*SW +: SW] ^ {SW{in_s.ctl.sub}};

    adder_slice #(.W(SW)) u_slice (
      .a    (in_s.a[k*SW +: SW]),
      .b    (sl_b),
      .cin  (in_s.ctl.cy),
      .s    (sl_s),
      .cout (sl_c),
      .cmsb (sl_m)
    );

    // Drop this slice's sum bits into the travelling partial sum.
    always_comb begin
      nx                 = in_s;
      nx.s[k*SW +: SW]   = sl_s;
      nx.ctl.cy          = sl_c;
      nx.ctl.ov          = sl_c ^ sl_m;
    end

    assign nxt[k] = nx;
  end

  // Stage registers: payload only captured for valid data, so a held or
  // drained output keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          if (nxt[k].ctl.vld) st_q[k] <= nxt[k];
          else                st_q[k].ctl.vld <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = st_q[STAGES-1].ctl.vld;
  assign sum       = st_q[STAGES-1].s;
  assign cout      = st_q[STAGES-1].ctl.cy;
  assign ovf       = st_q[STAGES-1].ctl.ov;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, STAGES=4) against a queue model.
// Checks directed corner cases, latency, stall/hold, reset flush and random traffic.
module tb_pipe_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         subv;
`ifdef PIPE_ADDER_SUB_EN
  logic         sub = 1'b0;
  assign subv = sub;
`else
  assign subv = 1'b0;
`endif

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           t;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_out = 0;
  bit   exact_lat = 1'b0;
  bit   accepted = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    exp_t         e;
    logic [W-1:0] yy;
    logic         c;
    longint       u;
    longint       sg;
    longint       lim;
    yy  = sb ? ~y : y;
    c   = sb ? 1'b1 : ci;
    u   = longint'(x) + longint'(yy) + longint'(c);
    sg  = longint'($signed(x)) + longint'($signed(yy)) + longint'(c);
    lim = longint'(1) << (W - 1);
    e.s = u[W-1:0];
    e.c = (u >= (longint'(1) << W));
    e.v = (sg > lim - 1) || (sg < -lim);
    e.t = 0;
    return e;
  endfunction

  // Handshakes are stable from negedge to the next posedge: sample them here.
  always @(negedge clk) begin
    cyc++;
    accepted = 1'b0;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        mon_e   = model(a, b, cin, subv);
        mon_e.t = cyc;
        q.push_back(mon_e);
        accepted = 1'b1;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        check_val("spurious_out", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check_val("sum", sum, mon_e.s);
          check_val("cout", cout, mon_e.c);
          check_val("ovf", ovf, mon_e.v);
          if (exact_lat) check_val("latency", cyc - mon_e.t, S);
        end
      end
    end
  end

  task automatic new_ops();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb,
                          input logic [W-1:0] es, input logic ec, input logic ev);
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; cin = ci;
`ifdef PIPE_ADDER_SUB_EN
    sub = sb;
`endif
    @(posedge clk); #1;           // handshake on this edge
    in_valid = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val({tag, "_early_valid"}, out_valid, 0);
    @(posedge clk); #1;
    check_val({tag, "_valid"}, out_valid, 1);
    check_val({tag, "_sum"}, sum, es);
    check_val({tag, "_cout"}, cout, ec);
    check_val({tag, "_ovf"}, ovf, ev);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    #1;
    check_val({tag, "_drained"}, q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc;
    int base_out;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_sum", sum, 0);
    check_val("rst_cout", cout, 0);
    check_val("rst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); #1;
    check_val("post_rst_in_ready", in_ready, 1);
    check_val("post_rst_out_valid", out_valid, 0);

    directed("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("cin_add",    16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
`ifdef PIPE_ADDER_SUB_EN
    directed("sub_neg",    16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`endif

    // Back-to-back stream with the output always ready.
    exact_lat = 1'b1;
    base_acc = n_acc;
    base_out = n_out;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      new_ops();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_val("b2b_accepted", n_acc - base_acc, 8);
    check_val("b2b_emitted", n_out - base_out, 8);
    exact_lat = 1'b0;

    // Output stalled for 10 cycles while the source keeps offering.
    base_acc = n_acc;
    base_out = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!in_valid || accepted) new_ops();
      in_valid = 1'b1;
      @(negedge clk); #1;
      if (out_valid && q.size() > 0) check_val("stall_hold_sum", sum, q[0].s);
    end
    check_val("stall_accepted", n_acc - base_acc, S);
    check_val("stall_in_ready", in_ready, 0);
    check_val("stall_out_valid", out_valid, 1);
    @(posedge clk); #1;
    drain("stall");
    check_val("stall_emitted", n_out - base_out, S);

    // Reset with three transactions in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      new_ops();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("pre_reset_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check_val("reset_out_valid", out_valid, 0);
    check_val("reset_sum", sum, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    base_out = n_out;
    repeat (10) @(posedge clk);
    #1;
    check_val("post_reset_emitted", n_out - base_out, 0);
    check_val("post_reset_in_ready", in_ready, 1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!in_valid || accepted) begin
        new_ops();
        in_valid = ($urandom_range(0, 9) < 7);
      end
      out_ready = ($urandom_range(0, 9) < 6);
    end
    @(posedge clk); #1;
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits, minimum 4.
REQ-002 SHALL have parameter STAGES, default 4: number of pipeline stages, minimum 1; WIDTH % STAGES == 0 SHALL be checked at elaboration.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operands presented.
REQ-006 in_ready  output  1  pipe accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, add mode only.
REQ-010 sub  input  1  subtract select; present only with PIPE_ADDER_SUB_EN.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of MSB (add) or no-borrow flag (subtract).
REQ-015 ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-016 Carry chain SHALL be split into STAGES slices of WIDTH/STAGES bits; stage k SHALL add slice k using the registered carry from stage k-1 (stage 0 uses cin).
REQ-017 Operand bits of later slices SHALL be skewed through registers; completed sum bits SHALL be carried forward, so each transaction stays aligned.
REQ-018 Latency SHALL be exactly STAGES cycles from input handshake to out_valid when out_ready is held high.
REQ-019 Transfer occurs on valid&&ready at either port; throughput SHALL be one result per cycle with out_ready held high.
REQ-020 Stage k SHALL load when it is empty or its contents advance this cycle; bubbles SHALL collapse.
REQ-021 in_ready SHALL be high when stage 0 is empty or advances; it SHALL NOT combinationally depend on in_valid.
REQ-022 While out_valid=1 and out_ready=0, sum/cout/ovf SHALL hold stable.
REQ-023 Results SHALL leave in acceptance order; no transaction SHALL be dropped or duplicated.
REQ-024 Simultaneous input accept and output take with a full pipe SHALL both complete in the same cycle.

Reset
REQ-025 rst_n low SHALL clear all stage valid bits immediately; out_valid=0, in_ready=1 after release.
REQ-026 sum, cout, ovf SHALL reset to 0; in-flight transactions at reset are discarded.

Configuration
REQ-027 Macro PIPE_ADDER_SUB_EN defined: port sub exists; sub=1 computes a + ~b + 1, ignoring cin; sub SHALL travel with its transaction.
REQ-028 Macro undefined: port sub absent; add only, a + b + cin.

Structure
REQ-029 Shared package pipe_adder_pkg SHALL hold the default WIDTH/STAGES constants and the per-stage payload typedef (valid, carry, operands, partial sum).
REQ-030 One sub-module, adder_slice, SHALL implement the combinational WIDTH/STAGES-bit slice add (a, b, cin -> s, cout, carry into MSB).

Verification (WIDTH=16, STAGES=4)
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
REQ-032 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-033 8 back-to-back inputs, out_ready=1 -> 8 results on consecutive cycles, in order, first after 4 cycles.
REQ-034 out_ready=0 for 10 cycles while streaming -> exactly 4 accepted, then in_ready=0; outputs stable; on release all drain in order.
REQ-035 rst_n pulsed low with 3 transactions in flight -> out_valid=0 immediately, nothing emitted after release.
REQ-036 With PIPE_ADDER_SUB_EN: a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
